// File: rtl/microcode_sequencer.sv
// Micro-instruction sequencer: decodes WRITE / READ-range / GO words and drives the
// sample memory, the streamed read-out port and the compute-core start/done handshake.
module microcode_sequencer #(
  parameter int RD_LATENCY = 1,
  parameter int GO_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic        instr_ready,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [14:0] mem_addr,
  output logic [14:0] mem_wr_data,
  input  logic [14:0] mem_rd_data,
  output logic        out_valid,
  output logic [14:0] out_data,
  input  logic        out_ready,
  output logic        core_go,
  input  logic        core_done,
  output logic        busy,
  output logic        err_range,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_SETUP,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT,
    S_GO_PULSE,
    S_GO_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cur;      // address field / read cursor; 16 bits so end=0x7FFF cannot wrap
  logic [14:0] lo;       // write data or read end address
  logic [14:0] rd_word;
  logic [2:0]  lat_cnt;
  logic [31:0] go_cnt;

  logic accept;
  logic range_empty;
  logic last_word;
  logic lat_done;
  logic timeout_hit;

  assign accept      = instr_valid && instr_ready;
  assign range_empty = ({1'b0, lo} < cur);
  assign last_word   = (cur == {1'b0, lo});
  assign lat_done    = (lat_cnt == 3'(RD_LATENCY));
  assign timeout_hit = (GO_TIMEOUT > 0) && (go_cnt == 32'(GO_TIMEOUT));

  // Gated by rst so the handshake is closed while reset is held.
  assign instr_ready = (state == S_IDLE) && !rst;
  assign busy        = (state != S_IDLE);
  assign mem_addr    = cur[14:0];
  assign mem_wr_data = (state == S_WRITE) ? lo : 15'd0;
  assign out_data    = rd_word;

  always_comb begin
    state_nxt   = state;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    out_valid   = 1'b0;
    core_go     = 1'b0;
    err_range   = 1'b0;
    err_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (instr_data[31])      state_nxt = S_GO_PULSE;
          else if (instr_data[30]) state_nxt = S_RD_SETUP;
          else                     state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_wr_en = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RD_SETUP: begin
        if (range_empty) begin
          err_range = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        mem_rd_en = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_done) state_nxt = S_RD_OUT;
      end
      S_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_word ? S_IDLE : S_RD_ISSUE;
      end
      S_GO_PULSE: begin
        core_go   = 1'b1;
        state_nxt = S_GO_WAIT;
      end
      S_GO_WAIT: begin
        if (core_done) begin
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          err_timeout = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cur     <= 16'd0;
      lo      <= 15'd0;
      rd_word <= 15'd0;
      lat_cnt <= 3'd0;
      go_cnt  <= 32'd0;
    end else begin
      state <= state_nxt;
      // GO words leave the address fields untouched so mem_addr keeps its last value.
      if (accept && !instr_data[31]) begin
        cur <= {1'b0, instr_data[29:15]};
        lo  <= instr_data[14:0];
      end
      if (state == S_RD_OUT && out_ready && !last_word) cur <= cur + 16'd1;
      if (state == S_RD_ISSUE)     lat_cnt <= 3'd1;
      else if (state == S_RD_WAIT) lat_cnt <= lat_cnt + 3'd1;
      if (state == S_RD_WAIT && lat_done) rd_word <= mem_rd_data;
      if (state == S_GO_PULSE)     go_cnt <= 32'd1;
      else if (state == S_GO_WAIT) go_cnt <= go_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed + randomized bench for microcode_sequencer with a behavioural memory and reference word list.
module tb_microcode_sequencer;

  localparam int RDL = 2;
  localparam int GTO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_data = 32'd0;
  logic        instr_ready;
  logic        mem_wr_en, mem_rd_en;
  logic [14:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        out_valid;
  logic [14:0] out_data;
  logic        out_ready = 1'b0;
  logic        core_go;
  logic        core_done = 1'b0;
  logic        busy, err_range, err_timeout;

  int checks = 0;
  int failures = 0;
  int ref_mem [0:32767];

  microcode_sequencer #(.RD_LATENCY(RDL), .GO_TIMEOUT(GTO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_go(core_go), .core_done(core_done), .busy(busy),
    .err_range(err_range), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Sample memory with a fixed read pipeline of RDL cycles.
  logic [14:0] mem  [0:32767];
  logic [14:0] pipe [0:RDL-1];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    pipe[0] <= mem_rd_en ? mem[mem_addr] : 15'h0;
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[RDL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) chk("wr_rd_exclusive", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);

  // Called at a negedge; returns at the negedge of the first post-accept cycle.
  task automatic send_instr(input logic [31:0] ins);
    int n = 0;
    while (!instr_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_send", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = $urandom;
  endtask

  task automatic do_write(input int a, input int d);
    send_instr({2'b00, 15'(a), 15'(d)});
    chk("wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("wr_addr", {17'd0, mem_addr}, 32'(a));
    chk("wr_data", {17'd0, mem_wr_data}, 32'(d));
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_back_idle", {31'd0, instr_ready}, 32'd1);
  endtask

  // mode 0: always ready, 1: ready one cycle in three, 2: random ready
  task automatic do_read(input int s, input int e, input int mode);
    int exp_words[$];
    int got = 0, strobes = 0, errs = 0, cyc = 0;
    logic stall = 1'b0;
    logic [14:0] held = 15'd0;
    for (int a = s; a <= e; a++) exp_words.push_back(ref_mem[a]);
    send_instr({2'b01, 15'(s), 15'(e)});
    while (busy && cyc < 3000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        chk("bp_data_held", {17'd0, out_data}, {17'd0, held});
      end
      if (mem_rd_en) begin
        chk("rd_addr", {17'd0, mem_addr}, 32'(s + strobes));
        strobes++;
      end
      if (err_range) errs++;
      if (out_valid && out_ready) begin
        if (got < exp_words.size()) chk("rd_word", {17'd0, out_data}, 32'(exp_words[got]));
        else chk("rd_extra_word", 32'(got), 32'(exp_words.size()));
        got++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("rd_finished", {31'd0, busy}, 32'd0);
    chk("rd_word_count", 32'(got), 32'(exp_words.size()));
    chk("rd_strobe_count", 32'(strobes), 32'(exp_words.size()));
    chk("rd_err_range", 32'(errs), (e < s) ? 32'd1 : 32'd0);
    if (e < s) chk("empty_read_cycles", 32'(cyc), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_instr_ready"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_en"}, {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"}, {17'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wr_data"}, {17'd0, mem_wr_data}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {17'd0, out_data}, 32'd0);
    chk({tag, "_core_go"}, {31'd0, core_go}, 32'd0);
    chk({tag, "_errs"}, {30'd0, err_range, err_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cyc;
    int s, len;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);

    // Explicit write: addr=5, data=5
    send_instr(32'h0002_8005);
    chk("w5_en", {31'd0, mem_wr_en}, 32'd1);
    chk("w5_addr", {17'd0, mem_addr}, 32'd5);
    chk("w5_data", {17'd0, mem_wr_data}, 32'd5);
    chk("w5_busy", {31'd0, busy}, 32'd1);
    ref_mem[5] = 5;
    @(negedge clk);
    chk("w5_ready_after", {31'd0, instr_ready}, 32'd1);
    chk("w5_strobe_single", {31'd0, mem_wr_en}, 32'd0);

    // Random preload of 0..31, then the directed 3..6 contents and the top address.
    for (int a = 0; a < 32; a++) do_write(a, $urandom_range(0, 32767));
    for (int a = 3; a <= 6; a++) do_write(a, 7 + a);
    do_write(32'h7FFF, $urandom_range(0, 32767));

    do_read(3, 6, 0);
    do_read(3, 6, 1);
    do_read(32'h7FFF, 32'h7FFF, 0);
    do_read(7, 2, 0);
    chk("after_empty_ready", {31'd0, instr_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      s   = $urandom_range(0, 25);
      len = $urandom_range(0, 6);
      do_read(s, s + len, 2);
    end

    // GO with done after a few cycles
    send_instr(32'h8000_0000);
    chk("go_pulse", {31'd0, core_go}, 32'd1);
    chk("go_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("go_single_pulse", {31'd0, core_go}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("go_wait_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("go_done_idle", {31'd0, busy}, 32'd0);
    chk("go_no_timeout", {31'd0, err_timeout}, 32'd0);

    // Bit30 set still decodes as GO; done during the pulse cycle is ignored, then timeout.
    send_instr(32'hC000_0000);
    chk("go2_pulse", {31'd0, core_go}, 32'd1);
    core_done = 1'b1;
    to_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      core_done = 1'b0;
      if (err_timeout) begin
        to_cyc = c;
        break;
      end
      chk("go2_busy", {31'd0, busy}, 32'd1);
      chk("go2_no_repulse", {31'd0, core_go}, 32'd0);
    end
    chk("timeout_cycle", 32'(to_cyc), 32'(GTO));
    @(negedge clk);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_single_pulse", {31'd0, err_timeout}, 32'd0);

    // Reset while a 10-word read is stalled in its output stage
    out_ready = 1'b0;
    send_instr({2'b01, 15'd10, 15'd19});
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    chk("midread_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midread_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    do_write(9, 32'h1234);
    do_read(8, 10, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Accepts 32-bit micro-instructions over a valid/ready handshake and decodes them with the team's fixed encoding.
- Executes each instruction in turn:
  - single-word memory writes;
  - inclusive address-range reads streamed out under backpressure;
  - accelerator "go" launches that wait for a done handshake.
- Sits between the host command FIFO and the on-chip sample memory / compute core.
- Processes one instruction at a time.

Parameters:
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..4).
- GO_TIMEOUT, 0, max cycles to wait for core_done after go; 0 means wait forever.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instruction available
- instr_data  input  32  micro-instruction
- instr_ready  output  1  sequencer accepts instruction this cycle
- mem_wr_en  output  1  memory write strobe
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  15  memory address, shared by read and write
- mem_wr_data  output  15  write data
- mem_rd_data  input  15  read data, valid RD_LATENCY cycles after mem_rd_en
- out_valid  output  1  read word available
- out_data  output  15  read word
- out_ready  input  1  downstream accepts read word
- core_go  output  1  one-cycle start pulse to compute core
- core_done  input  1  core completion, level or pulse
- busy  output  1  high in any state except IDLE
- err_range  output  1  one-cycle pulse: empty read range (end < start)
- err_timeout  output  1  one-cycle pulse: GO_TIMEOUT expired

Behaviour:
- Decode, priority order:
  - instr[31]=1 → GO, regardless of bit 30.
  - instr[31:30]=00 → WRITE, addr=instr[29:15], data=instr[14:0].
  - instr[31:30]=01 → READ, start=instr[29:15], end=instr[14:0], inclusive.
- Reset: clk/rst synchronous active-high.
  - State=IDLE.
  - All outputs 0: instr_ready, mem_*, out_*, core_go, busy, err_*.
  - Reset mid-operation aborts the operation immediately; no partial word is held; core_go is not re-issued.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register the instruction and fields, then go to the decoded state next cycle.
  - instr_ready=0 in every other state.
- WRITE (1 cycle): mem_wr_en=1, mem_addr=addr, mem_wr_data=data → IDLE. Write latency accept→strobe = 1 cycle.
- READ setup:
  - If end < start: pulse err_range, no memory access, → IDLE.
  - Otherwise load a 16-bit counter cur=start → RD_ISSUE.
- RD_ISSUE (1 cycle): mem_rd_en=1, mem_addr=cur[14:0] → RD_WAIT.
- RD_WAIT:
  - Count RD_LATENCY cycles from the strobe.
  - Capture mem_rd_data into the output register → RD_OUT.
- RD_OUT:
  - out_valid=1 with out_data stable until out_ready.
  - On out_valid&&out_ready:
    - if cur==end → IDLE;
    - else cur=cur+1 → RD_ISSUE.
  - The 16-bit counter prevents wrap at end=0x7FFF.
  - Exactly end-start+1 words are emitted, in ascending order, with no duplicates or gaps.
- GO:
  - GO_PULSE (1 cycle): core_go=1 → GO_WAIT.
  - GO_WAIT:
    - core_done=1 → IDLE.
    - If GO_TIMEOUT>0 and GO_TIMEOUT cycles elapse without done: pulse err_timeout → IDLE.
    - core_done is ignored outside GO_WAIT, including the GO_PULSE cycle.
- busy = (state != IDLE).
- mem_wr_en and mem_rd_en are never high in the same cycle.
- mem_addr holds its last value when idle (don't-care).
- Back-to-back instructions:
  - The next accept happens no earlier than the cycle the FSM is in IDLE.
  - Minimum per-instruction period: WRITE 2 cycles; empty READ 2 cycles.

Test Plan:
- Write: instr 0x0002_8005 (addr=5, data=5) → one cycle later mem_wr_en=1, mem_addr=5, mem_wr_data=5; then instr_ready=1.
- Read range: preload addr 3..6 = {10,11,12,13}; instr READ start=3, end=6, out_ready=1 → out_data 10,11,12,13 in order, 4 handshakes, then IDLE.
- Backpressure: same read with out_ready toggling 1-in-3 → out_data stable while out_valid&&!out_ready, no drops or duplicates, 4 words total.
- Boundaries:
  - start=end=0x7FFF → exactly one word, no wrap.
  - start=7, end=2 → err_range pulse, zero mem_rd_en, back in IDLE within 2 cycles.
- Go: instr 0x8000_0000 → core_go for exactly 1 cycle; busy held until core_done. Instr 0xC000_0000 also decodes as GO. GO_TIMEOUT=16 with no done → err_timeout at cycle 16, then IDLE.
- Reset mid-read: assert rst during RD_OUT of a 10-word range → next cycle all outputs 0, state IDLE; a new WRITE then executes normally.
